ospi_flash_ctrl: RTL
====================

# ospi_flash_ctrl

Host-side burst sequencer that sits directly upstream of the OSPI flash model. It accepts read, write and erase requests over a valid/ready handshake and expands each one into a chip-select-framed sequence of single-byte flash strobes with an auto-incrementing address. It returns read bytes over a valid/ready response channel. It also honours the flash's hold protocol, which has a one-cycle lag.

## Interface
Parameters:
- CS_HIGH_CYCLES, 2: minimum cycles flash_cs stays high between transactions (≥1).
- ADDR_W, 24: flash address width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid / req_ready  in / out  1 / 1  request handshake; accepted on a cycle where both are high.
- req_op  in  2  operation: 0 = read, 1 = write, 2 = erase, 3 = NOP.
- req_addr  in  ADDR_W  start address.
- req_len  in  4  burst length minus 1 (1–16 bytes).
- wdata_valid / wdata_ready  in / out  1 / 1  write-byte handshake (used for writes only).
- wdata  in  8  write byte.
- rsp_valid / rsp_ready  out / in  1 / 1  read-byte handshake.
- rsp_data  out  8  read byte.
- rsp_last  out  1  high with the final byte of a read burst.
- op_done  out  1  one-cycle pulse when a transaction ends.
- busy  out  1  high whenever state ≠ IDLE.
- hold_req  in  1  host request to pause the flash.
- flash_cs  out  1  active-low chip select to the flash.
- flash_we, flash_re, flash_ee  out  1 each  flash write, read and erase strobes.
- flash_addr  out  ADDR_W  flash address.
- flash_wdata  out  8  flash write data.
- flash_rdata  in  8  flash data_out.
- flash_hold_n  out  1  drives the flash HOLD_N input.

## Operation
States are IDLE, SETUP, ACCESS, DRAIN and TEARDOWN.

- **IDLE:** req_ready = 1.
  - Op 0–2 is latched as op, addr and remaining count = req_len. Next state SETUP.
  - Op 3 (NOP) goes straight to TEARDOWN and pulses op_done; flash_cs is never lowered.
- **SETUP:** one cycle. flash_cs = 0 and all strobes = 0. Next state ACCESS.
- **ACCESS:** an issue cycle asserts exactly one strobe with flash_addr = addr. After each issue, addr increments modulo 2^ADDR_W and the count decrements.
  - The issue gate is `!hold_req && !hold_q`, where hold_q is hold_req registered once. This matches the flash's registered hold_active.
  - Write: issue when wdata_valid is high. wdata_ready = gate; flash_wdata = wdata.
  - Erase: issue every gated cycle.
  - Read: issue when the gate is open, no read is pending (rd_pend = 0), and (!rsp_valid || rsp_ready).
  - After the last issue: a read moves to DRAIN; a write or erase moves to TEARDOWN.
- **DRAIN:** wait until the last read byte has been captured into the response register. Then go to TEARDOWN.
- **TEARDOWN:**
  - flash_cs = 1, and op_done pulses on entry.
  - A counter runs CS_HIGH_CYCLES cycles, then the state returns to IDLE.
  - rsp_valid may still be high during TEARDOWN; the block does not wait for rsp_ready.
- **Read capture:**
  - A read issued in cycle t sets rd_pend.
  - flash_rdata is valid in cycle t+1. At the end of t+1 it is captured into rsp_data, rsp_valid is set, and rd_pend clears.
  - rsp_last = 1 when the captured byte is the final byte of the burst.
  - rsp_valid clears on a cycle where rsp_valid && rsp_ready and no new capture occurs.
- **Outside ACCESS:** all strobes are 0.
- **Reserved or illegal combinations:** none; the strobes are mutually exclusive by construction.

## Timing
- **Reset values:**
  - State IDLE; req_ready = 1.
  - flash_cs = 1; flash_we, flash_re, flash_ee = 0.
  - flash_addr = 0; flash_wdata = 0; flash_hold_n = 1.
  - rsp_valid = 0, rsp_data = 0, rsp_last = 0.
  - wdata_ready = 0, op_done = 0, busy = 0, hold_q = 0.
- **Latency:**
  - Request acceptance to first strobe is 2 cycles (the IDLE→SETUP edge, then SETUP).
  - A read strobe in cycle t gives rsp_valid in cycle t+2.
  - Read throughput is at most 1 byte per 2 cycles. Write and erase throughput is 1 byte per cycle.
- **Hold:**
  - flash_hold_n = !hold_req, combinational.
  - Rising hold_req blocks issue in the same cycle.
  - After hold_req falls, issue resumes 2 cycles later (once hold_q clears).
  - flash_cs stays low throughout the hold.
- **Address:** wraps from 0xFFFFFF to 0x000000 within a burst without a break.
- **Reset mid-burst:** flash_cs rises and all strobes drop asynchronously. The burst is abandoned and op_done does not pulse.
- **Back-to-back requests:** flash_cs is high for at least CS_HIGH_CYCLES cycles between transactions.

## Configuration
- **OSPI_CTRL_HOLD_EN defined:** hold_req, hold_q and the issue gate behave as described above.
- **OSPI_CTRL_HOLD_EN undefined:**
  - The hold_req port remains but is ignored.
  - flash_hold_n is tied to 1.
  - The issue gate is always open, and hold_q is not instantiated.

## Structure
- Package ospi_ctrl_pkg holds:
  - the op encoding constants (OP_READ, OP_WRITE, OP_ERASE, OP_NOP);
  - the state enumeration;
  - the default CS_HIGH_CYCLES.
- One sub-module, ospi_ctrl_rsp_reg, holds the single-entry read-response register: capture, rsp_valid/rsp_ready and rsp_last.
- The FSM, counters and address incrementer live in the top module.

## Test plan
- **Write burst:** write, addr 0x000010, len 3, bytes A1 A2 A3 A4 → flash_we on 4 consecutive cycles at addresses 0x10–0x13; flash_cs low for SETUP + 4 cycles; op_done pulses once.
- **Read burst:** read back 0x10, len 3 → rsp_data A1, A2, A3, A4; rsp_last only with A4; each rsp_valid lands 2 cycles after its flash_re.
- **Response backpressure:** rsp_ready held low for 5 cycles during a 4-byte read → no further flash_re while rsp_valid is high; no byte lost or duplicated.
- **Hold:** hold_req pulsed high for 3 cycles mid-erase, 8 bytes from 0xFFFFFE → no strobe while hold_req or hold_q is high; addresses 0xFFFFFE, 0xFFFFFF, 0x000000 … 0x000005 erased; flash_cs never rises. With OSPI_CTRL_HOLD_EN undefined, the same stimulus produces no stall.
- **NOP then read:** NOP, then a read → flash_cs never low for the NOP; op_done pulses; flash_cs high for ≥ 2 cycles before the read's SETUP.
- **Reset mid-burst:** reset_n pulsed low during the 3rd byte of a write → flash_cs = 1 and all strobes = 0 immediately; all outputs at reset values; the next request completes normally.

Source files
------------

// File: rtl/ospi_ctrl_pkg.sv
// Shared op encodings, FSM state codes and defaults for the OSPI flash burst sequencer.
package ospi_ctrl_pkg;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_SETUP    = 3'd1;
  localparam state_t ST_ACCESS   = 3'd2;
  localparam state_t ST_DRAIN    = 3'd3;
  localparam state_t ST_TEARDOWN = 3'd4;

  localparam int unsigned CS_HIGH_CYCLES_DEF = 2;

endpackage

// File: rtl/ospi_flash_ctrl_if.sv
// Host-side request, write-data and read-response channels of the OSPI burst sequencer.
interface ospi_flash_ctrl_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [7:0]        wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_data;
  logic              rsp_last;

  modport master (
    output req_valid, req_op, req_addr, req_len, wdata_valid, wdata, rsp_ready,
    input  req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_len, wdata_valid, wdata, rsp_ready,
    output req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/ospi_ctrl_rsp_reg.sv
// Single-entry read-response register: captures a flash byte and holds it until the host takes it.
module ospi_ctrl_rsp_reg (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cap_en,
  input  logic [7:0] cap_data,
  input  logic       cap_last,
  input  logic       rsp_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_last
);
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (cap_en) begin
      valid_d = 1'b1;
      data_d  = cap_data;
      last_d  = cap_last;
    end else if (valid_q && rsp_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
  assign rsp_last  = last_q;
endmodule

// File: rtl/ospi_flash_ctrl.sv
// OSPI flash burst sequencer: expands host requests into CS-framed single-byte strobes.
// Optional hold support is compiled in with OSPI_CTRL_HOLD_EN.
module ospi_flash_ctrl
  import ospi_ctrl_pkg::*;
#(
  parameter int unsigned CS_HIGH_CYCLES = CS_HIGH_CYCLES_DEF,
  parameter int unsigned ADDR_W         = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  ospi_flash_ctrl_if.slave  host,
  output logic              op_done,
  output logic              busy,
  input  logic              hold_req,
  output logic              flash_cs,
  output logic              flash_we,
  output logic              flash_re,
  output logic              flash_ee,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [7:0]        flash_wdata,
  input  logic [7:0]        flash_rdata,
  output logic              flash_hold_n
);
  localparam int unsigned TC_W = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(CS_HIGH_CYCLES - 1);

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [TC_W-1:0]   tcnt_q, tcnt_d;
  logic              op_done_q, op_done_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_last_q, rd_last_d;
  logic              gate, in_access, we_iss, re_iss, ee_iss, issue;
  logic              rsp_valid_w, rsp_last_w;
  logic [7:0]        rsp_data_w;

`ifdef OSPI_CTRL_HOLD_EN
  // hold_q mirrors the flash's registered hold_active, so issue stays blocked one cycle past hold_req.
  logic hold_q, hold_d;
  always_comb hold_d = hold_req;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hold_q <= 1'b0;
    else          hold_q <= hold_d;
  end
  assign gate         = !hold_req && !hold_q;
  assign flash_hold_n = !hold_req;
`else
  logic unused_hold_req;
  assign unused_hold_req = hold_req;
  assign gate            = 1'b1;
  assign flash_hold_n    = 1'b1;
`endif

  assign in_access = (state_q == ST_ACCESS);
  assign we_iss    = in_access && (op_q == OP_WRITE) && gate && host.wdata_valid;
  assign ee_iss    = in_access && (op_q == OP_ERASE) && gate;
  // A read only goes out once the response register is guaranteed empty at its capture cycle.
  assign re_iss    = in_access && (op_q == OP_READ) && gate && !rd_pend_q &&
                     (!rsp_valid_w || host.rsp_ready);
  assign issue     = we_iss || re_iss || ee_iss;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    tcnt_d    = '0;
    rd_pend_d = re_iss;
    rd_last_d = re_iss && (cnt_q == 4'd0);
    case (state_q)
      ST_IDLE: begin
        if (host.req_valid) begin
          if (host.req_op == OP_NOP) begin
            state_d = ST_TEARDOWN;
          end else begin
            op_d    = host.req_op;
            addr_d  = host.req_addr;
            cnt_d   = host.req_len;
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - 4'd1;
          if (cnt_q == 4'd0) state_d = (op_q == OP_READ) ? ST_DRAIN : ST_TEARDOWN;
        end
      end
      ST_DRAIN: begin
        if (rd_pend_q) state_d = ST_TEARDOWN;
      end
      ST_TEARDOWN: begin
        if (tcnt_q == TC_LAST) state_d = ST_IDLE;
        else                   tcnt_d  = tcnt_q + TC_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    op_done_d = (state_d == ST_TEARDOWN) && (state_q != ST_TEARDOWN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_READ;
      addr_q    <= '0;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      op_done_q <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      op_done_q <= op_done_d;
      rd_pend_q <= rd_pend_d;
      rd_last_q <= rd_last_d;
    end
  end

  ospi_ctrl_rsp_reg u_rsp_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .cap_en    (rd_pend_q),
    .cap_data  (flash_rdata),
    .cap_last  (rd_last_q),
    .rsp_ready (host.rsp_ready),
    .rsp_valid (rsp_valid_w),
    .rsp_data  (rsp_data_w),
    .rsp_last  (rsp_last_w)
  );

  assign host.rsp_valid   = rsp_valid_w;
  assign host.rsp_data    = rsp_data_w;
  assign host.rsp_last    = rsp_last_w;
  assign host.req_ready   = (state_q == ST_IDLE);
  assign host.wdata_ready = in_access && (op_q == OP_WRITE) && gate;

  assign busy        = (state_q != ST_IDLE);
  assign op_done     = op_done_q;
  assign flash_cs    = !((state_q == ST_SETUP) || in_access || (state_q == ST_DRAIN));
  assign flash_we    = we_iss;
  assign flash_re    = re_iss;
  assign flash_ee    = ee_iss;
  assign flash_addr  = addr_q;
  assign flash_wdata = (in_access && (op_q == OP_WRITE)) ? host.wdata : '0;
endmodule
